// File: rtl/frv_mem_response.sv
// frv_mem_response: LSU memory response tracker that aligns/extends load data and reports bus errors as traps.
module frv_mem_response #(
  parameter logic [4:0] LD_FAULT_CAUSE = 5'd5,
  parameter logic [4:0] ST_FAULT_CAUSE = 5'd7
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        s4_valid,
  output logic        s4_busy,
  input  logic        s4_load,
  input  logic        s4_signed,
  input  logic [1:0]  s4_size,
  input  logic [1:0]  s4_addr_lo,
  input  logic [4:0]  s4_rd,
  input  logic        dmem_recv,
  output logic        dmem_ack,
  input  logic        dmem_error,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  input  logic        wb_busy,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_wdata,
  output logic        wb_trap,
  output logic [4:0]  wb_cause
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;
  state_t state, state_nxt;
  logic        ld_q, sg_q, accept, capture, ok;
  logic [1:0]  size_q, lo_q;
  logic [4:0]  rd_q;
  logic [31:0] shifted, ext;
  assign s4_busy  = state == WAIT || state == DRAIN || (state == DONE && wb_busy);
  assign dmem_ack = state == WAIT || state == DRAIN;
  assign wb_valid = state == DONE;
  assign accept   = s4_valid && !s4_busy && !flush;
  assign capture  = state == WAIT && dmem_recv && !flush;
  assign ok       = ld_q && !dmem_error;
  assign shifted  = size_q == 2'b00 ? dmem_rdata >> {lo_q, 3'b000} :
                    size_q == 2'b01 ? dmem_rdata >> {lo_q[1], 4'b0000} : dmem_rdata;
  assign ext      = size_q == 2'b00 ? {{24{sg_q & shifted[7]}}, shifted[7:0]} :
                    size_q == 2'b01 ? {{16{sg_q & shifted[15]}}, shifted[15:0]} : shifted;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? WAIT : IDLE;
      WAIT:    state_nxt = flush ? (dmem_recv ? IDLE : DRAIN) : (dmem_recv ? DONE : WAIT);
      DONE:    state_nxt = flush ? IDLE : wb_busy ? DONE : accept ? WAIT : IDLE;
      DRAIN:   state_nxt = dmem_recv ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state    <= IDLE;
      ld_q     <= 1'b0;
      sg_q     <= 1'b0;
      size_q   <= 2'b00;
      lo_q     <= 2'b00;
      rd_q     <= 5'd0;
      wb_rd    <= 5'd0;
      wb_wdata <= 32'd0;
      wb_trap  <= 1'b0;
      wb_cause <= 5'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ld_q   <= s4_load;
        sg_q   <= s4_signed;
        size_q <= s4_size;
        lo_q   <= s4_addr_lo;
        rd_q   <= s4_rd;
      end
      if (capture) begin
        wb_rd    <= ok ? rd_q : 5'd0;
        wb_wdata <= ok ? ext : 32'd0;
        wb_trap  <= dmem_error;
        wb_cause <= dmem_error ? (ld_q ? LD_FAULT_CAUSE : ST_FAULT_CAUSE) : 5'd0;
      end
    end
  end
endmodule

// File: tb/tb_frv_mem_response.sv
// tb_frv_mem_response: directed self-checking bench for frv_mem_response.
module tb_frv_mem_response;
  logic g_clk = 0, g_reset = 1, flush = 0, s4_valid = 0, s4_load = 0, s4_signed = 0;
  logic dmem_recv = 0, dmem_error = 0, wb_busy = 0;
  logic [1:0] s4_size = 0, s4_addr_lo = 0;
  logic [4:0] s4_rd = 0;
  logic [31:0] dmem_rdata = 0;
  logic s4_busy, dmem_ack, wb_valid, wb_trap;
  logic [4:0] wb_rd, wb_cause;
  logic [31:0] wb_wdata;
  int n_chk = 0, n_fail = 0;

  frv_mem_response dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush), .s4_valid(s4_valid), .s4_busy(s4_busy),
    .s4_load(s4_load), .s4_signed(s4_signed), .s4_size(s4_size), .s4_addr_lo(s4_addr_lo),
    .s4_rd(s4_rd), .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_busy(wb_busy), .wb_rd(wb_rd),
    .wb_wdata(wb_wdata), .wb_trap(wb_trap), .wb_cause(wb_cause)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge g_clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic sg, input logic [1:0] sz, input logic [1:0] lo, input logic [4:0] rd);
    s4_valid = 1; s4_load = ld; s4_signed = sg; s4_size = sz; s4_addr_lo = lo; s4_rd = rd;
    step;
    s4_valid = 0;
  endtask

  task automatic respond(input logic err, input logic [31:0] d);
    dmem_recv = 1; dmem_error = err; dmem_rdata = d;
    step;
    dmem_recv = 0; dmem_error = 0;
  endtask

  task automatic expect_wb(input string tag, input logic v, input logic [4:0] rd, input logic [31:0] wd, input logic tr, input logic [4:0] ca);
    check({tag, "_valid"}, wb_valid, v);
    check({tag, "_rd"}, wb_rd, rd);
    check({tag, "_wdata"}, wb_wdata, wd);
    check({tag, "_trap"}, wb_trap, tr);
    check({tag, "_cause"}, wb_cause, ca);
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_busy"}, s4_busy, 0);
    check({tag, "_ack"}, dmem_ack, 0);
    expect_wb(tag, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #2;
    expect_quiet("reset");
    step; step;
    g_reset = 0;
    step;
    expect_quiet("post_reset");
    // signed byte at lane 3
    issue(1, 1, 2'b00, 2'b11, 5'd5);
    check("sb_wait_busy", s4_busy, 1);
    check("sb_wait_ack", dmem_ack, 1);
    check("sb_wait_valid", wb_valid, 0);
    respond(0, 32'h80AB_CDEF);
    expect_wb("sb", 1, 5'd5, 32'hFFFF_FF80, 0, 0);
    check("sb_done_busy", s4_busy, 0);
    check("sb_done_ack", dmem_ack, 0);
    step;
    check("sb_retire_valid", wb_valid, 0);
    issue(1, 0, 2'b01, 2'b10, 5'd9);
    respond(0, 32'h8001_1234);
    expect_wb("uh", 1, 5'd9, 32'h0000_8001, 0, 0);
    step;
    issue(1, 1, 2'b01, 2'b10, 5'd9);
    respond(0, 32'h8001_1234);
    expect_wb("sh", 1, 5'd9, 32'hFFFF_8001, 0, 0);
    step;
    issue(1, 0, 2'b00, 2'b01, 5'd3);
    respond(0, 32'h80AB_CDEF);
    expect_wb("ub", 1, 5'd3, 32'h0000_00CD, 0, 0);
    step;
    issue(1, 1, 2'b10, 2'b00, 5'd31);
    respond(0, 32'h80AB_CDEF);
    expect_wb("lw", 1, 5'd31, 32'h80AB_CDEF, 0, 0);
    step;
    issue(0, 0, 2'b10, 2'b00, 5'd7);
    respond(1, 32'hDEAD_BEEF);
    expect_wb("st_err", 1, 0, 0, 1, 5'd7);
    step;
    issue(1, 1, 2'b10, 2'b00, 5'd4);
    respond(1, 32'h1234_5678);
    expect_wb("ld_err", 1, 0, 0, 1, 5'd5);
    step;
    issue(0, 0, 2'b10, 2'b00, 5'd6);
    respond(0, 32'hFFFF_FFFF);
    expect_wb("st_ok", 1, 0, 0, 0, 0);
    step;
    // writeback stall, stray beat in DONE, then back-to-back accept
    issue(1, 0, 2'b00, 2'b00, 5'd12);
    respond(0, 32'h0000_00A5);
    wb_busy = 1;
    #1;
    check("stall_busy0", s4_busy, 1);
    for (int i = 0; i < 3; i++) begin
      dmem_recv = (i == 0); dmem_rdata = 32'hFFFF_FFFF;
      step;
      dmem_recv = 0;
      expect_wb($sformatf("stall%0d", i), 1, 5'd12, 32'h0000_00A5, 0, 0);
      check($sformatf("stall%0d_busy", i), s4_busy, 1);
    end
    wb_busy = 0;
    s4_valid = 1; s4_load = 1; s4_signed = 1; s4_size = 2'b01; s4_addr_lo = 2'b00; s4_rd = 5'd2;
    #1;
    check("b2b_busy", s4_busy, 0);
    step;
    s4_valid = 0;
    check("b2b_valid", wb_valid, 0);
    check("b2b_ack", dmem_ack, 1);
    respond(0, 32'h0000_F00F);
    expect_wb("b2b", 1, 5'd2, 32'hFFFF_F00F, 0, 0);
    step;
    // flush in WAIT, beat arrives two cycles later and is drained
    issue(1, 0, 2'b10, 2'b00, 5'd8);
    flush = 1;
    step;
    flush = 0;
    check("drain_ack", dmem_ack, 1);
    check("drain_busy", s4_busy, 1);
    check("drain_valid", wb_valid, 0);
    flush = 1;
    step;
    flush = 0;
    check("drain_flush_ack", dmem_ack, 1);
    dmem_recv = 1; dmem_rdata = 32'h1111_1111;
    #1;
    check("drain_beat_ack", dmem_ack, 1);
    step;
    dmem_recv = 0;
    check("drain_end_ack", dmem_ack, 0);
    check("drain_end_busy", s4_busy, 0);
    check("drain_end_valid", wb_valid, 0);
    step;
    check("drain_idle_valid", wb_valid, 0);
    check("drain_idle_wdata", wb_wdata, 32'hFFFF_F00F);
    issue(1, 0, 2'b10, 2'b00, 5'd8);
    flush = 1; dmem_recv = 1; dmem_rdata = 32'h2222_2222;
    step;
    flush = 0; dmem_recv = 0;
    check("fl_recv_valid", wb_valid, 0);
    check("fl_recv_ack", dmem_ack, 0);
    check("fl_recv_busy", s4_busy, 0);
    issue(1, 0, 2'b10, 2'b00, 5'd13);
    respond(0, 32'h0000_55AA);
    expect_wb("pre_fl", 1, 5'd13, 32'h0000_55AA, 0, 0);
    wb_busy = 1; flush = 1;
    step;
    flush = 0; wb_busy = 0;
    check("fl_done_valid", wb_valid, 0);
    check("fl_done_busy", s4_busy, 0);
    // asynchronous reset mid-transaction
    issue(1, 0, 2'b10, 2'b00, 5'd17);
    check("rst_pre_ack", dmem_ack, 1);
    g_reset = 1;
    #1;
    expect_quiet("async_rst");
    step;
    g_reset = 0;
    step;
    respond(0, 32'h3333_3333);
    expect_quiet("rst_stray");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
